// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and
// decoder-side valid/ready handoff with the accepted-transfer counter.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_cnt,
    input  imem_rdata, imem_rvalid, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, fetch_cnt,
    output imem_rdata, imem_rvalid, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues one memory request at a time,
// holds the returned word for the decoder and follows branch redirects.
//
// state     | meaning
// S_FETCH   | drive imem_req for pc (gated off by a redirect)
// S_WAIT    | request outstanding, response is wanted
// S_HOLD    | instruction presented to decoder, waiting for out_ready
// S_DISCARD | request outstanding but made stale by a redirect; drop response
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] opc_q, opc_nxt;
  logic [31:0] cnt_q, cnt_nxt;
  logic        req;
  logic [31:0] redir_al;

  assign redir_al = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC_AL;
      instr_q <= NOP_INSTR;
      opc_q   <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      opc_q   <= opc_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    opc_nxt   = opc_q;
    cnt_nxt   = cnt_q;
    req       = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.redirect_valid) begin
          pc_nxt = redir_al;
        end else begin
          req       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          // A response landing with the redirect is already stale; nothing left to drain.
          pc_nxt    = redir_al;
          state_nxt = bus.imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (bus.imem_rvalid) begin
          instr_nxt = bus.imem_rdata;
          opc_nxt   = pc;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          cnt_nxt = cnt_q + 32'd1;
        end
        if (bus.redirect_valid) begin
          pc_nxt    = redir_al;
          state_nxt = S_FETCH;
        end else if (bus.out_ready) begin
          state_nxt = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (bus.redirect_valid) begin
          pc_nxt = redir_al;
        end
        if (bus.imem_rvalid) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset forces FETCH, so the strobe is also masked by rst_n to stay low during reset.
  assign bus.imem_req  = req & rst_n;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_instr = instr_q;
  assign bus.out_pc    = opc_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responses are driven cycle by cycle with
// hand-computed expectations for handoff, back-pressure, redirects, wrap and reset.
module tb_instr_fetch;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  instr_fetch_if ifc();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifc.imem_rdata = 32'h0;
    ifc.imem_rvalid = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.out_ready = 1'b0;

    // reset values
    tick(); tick();
    chk("rst_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("rst_instr", ifc.out_instr, 32'h0000_0013);
    chk("rst_opc", ifc.out_pc, 32'h0);
    chk("rst_cnt", ifc.fetch_cnt, 32'h0);

    // first fetch, 1-cycle memory, out_ready=1
    rst_n = 1'b1; ifc.out_ready = 1'b1;
    settle();
    chk("f1_req", {31'h0, ifc.imem_req}, 32'h1);
    chk("f1_addr", ifc.imem_addr, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0050_0093;
    settle();
    chk("f1_wait_req", {31'h0, ifc.imem_req}, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b0;
    settle();
    chk("f1_valid", {31'h0, ifc.out_valid}, 32'h1);
    chk("f1_instr", ifc.out_instr, 32'h0050_0093);
    chk("f1_opc", ifc.out_pc, 32'h0);
    tick();
    chk("f1_next_req", {31'h0, ifc.imem_req}, 32'h1);
    chk("f1_next_addr", ifc.imem_addr, 32'h4);
    chk("f1_cnt", ifc.fetch_cnt, 32'h1);
    chk("f1_valid_drop", {31'h0, ifc.out_valid}, 32'h0);

    // back-pressure for 5 cycles in HOLD; a stray rvalid in HOLD is ignored
    ifc.out_ready = 1'b0;
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hAAAA_0001;
    tick();
    ifc.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifc.imem_rvalid = (i == 2);
      ifc.imem_rdata = 32'h5555_5555;
      settle();
      chk("bp_valid", {31'h0, ifc.out_valid}, 32'h1);
      chk("bp_instr", ifc.out_instr, 32'hAAAA_0001);
      chk("bp_opc", ifc.out_pc, 32'h4);
      chk("bp_req", {31'h0, ifc.imem_req}, 32'h0);
      tick();
    end
    ifc.imem_rvalid = 1'b0;
    ifc.out_ready = 1'b1;
    settle();
    chk("bp_valid_last", {31'h0, ifc.out_valid}, 32'h1);
    tick();
    chk("bp_next_req", {31'h0, ifc.imem_req}, 32'h1);
    chk("bp_next_addr", ifc.imem_addr, 32'h8);
    chk("bp_cnt", ifc.fetch_cnt, 32'h2);

    // redirect in WAIT to 0x103, memory latency 3: stale response dropped
    tick();
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h0000_0103;
    settle();
    chk("rw_req", {31'h0, ifc.imem_req}, 32'h0);
    tick();
    ifc.redirect_valid = 1'b0;
    settle();
    chk("rw_d1_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("rw_d1_req", {31'h0, ifc.imem_req}, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rw_d2_valid", {31'h0, ifc.out_valid}, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b0;
    settle();
    chk("rw_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("rw_req2", {31'h0, ifc.imem_req}, 32'h1);
    chk("rw_addr", ifc.imem_addr, 32'h0000_0100);

    // redirect together with rvalid in WAIT, target 0x200
    tick();
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h200;
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0BAD_0BAD;
    tick();
    ifc.redirect_valid = 1'b0; ifc.imem_rvalid = 1'b0;
    settle();
    chk("rr_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("rr_req", {31'h0, ifc.imem_req}, 32'h1);
    chk("rr_addr", ifc.imem_addr, 32'h200);
    chk("rr_cnt", ifc.fetch_cnt, 32'h2);

    // redirect in FETCH gates the request; low bits of target ignored; wrap at top
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'hFFFF_FFFF;
    settle();
    chk("rf_req", {31'h0, ifc.imem_req}, 32'h0);
    tick();
    ifc.redirect_valid = 1'b0;
    settle();
    chk("rf_req2", {31'h0, ifc.imem_req}, 32'h1);
    chk("rf_addr", ifc.imem_addr, 32'hFFFF_FFFC);
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h1234_5678;
    tick();
    ifc.imem_rvalid = 1'b0;
    settle();
    chk("wrap_instr", ifc.out_instr, 32'h1234_5678);
    chk("wrap_opc", ifc.out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", ifc.imem_addr, 32'h0);
    chk("wrap_cnt", ifc.fetch_cnt, 32'h3);

    // redirect in HOLD while out_ready is high: still counts as accepted
    ifc.out_ready = 1'b0;
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0000_1111;
    tick();
    ifc.imem_rvalid = 1'b0;
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h300; ifc.out_ready = 1'b1;
    settle();
    chk("rh_valid", {31'h0, ifc.out_valid}, 32'h1);
    tick();
    ifc.redirect_valid = 1'b0;
    settle();
    chk("rh_valid2", {31'h0, ifc.out_valid}, 32'h0);
    chk("rh_addr", ifc.imem_addr, 32'h300);
    chk("rh_cnt", ifc.fetch_cnt, 32'h4);

    // reset during WAIT; late response arrives while back in FETCH
    tick();
    rst_n = 1'b0;
    settle();
    chk("mr_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("mr_cnt", ifc.fetch_cnt, 32'h0);
    chk("mr_instr", ifc.out_instr, 32'h0000_0013);
    tick(); tick();
    rst_n = 1'b1;
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hBEEF_BEEF;
    settle();
    chk("mr_req2", {31'h0, ifc.imem_req}, 32'h1);
    chk("mr_addr", ifc.imem_addr, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0060_0113;
    settle();
    chk("mr_wait_valid", {31'h0, ifc.out_valid}, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b0;
    settle();
    chk("mr_valid", {31'h0, ifc.out_valid}, 32'h1);
    chk("mr_instr2", ifc.out_instr, 32'h0060_0113);
    chk("mr_opc", ifc.out_pc, 32'h0);
    chk("mr_cnt2", ifc.fetch_cnt, 32'h0);
    tick();
    chk("mr_next_addr", ifc.imem_addr, 32'h4);
    chk("mr_cnt3", ifc.fetch_cnt, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
